cbfp_exp_detect: RTL

// - Upstream neighbour of the CBFP shift stage. Collects butterfly outputs into 16-sample blocks.
// - Per block, finds the minimum redundant-sign-bit count (RSB) separately over real and imag parts.
// - Emits the whole block with shift_amt_re/shift_amt_im. Downstream scales by (amt-12): left if amt>12, right if amt<12.
// - Ping-pong buffered so input streaming continues while the consumer stalls.

---
 rtl/cbfp_exp_detect.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cbfp_exp_detect.sv
// CBFP exponent detector: gathers LANES-wide beats into DATA_NUM-sample ping-pong banks and reports
// the block-wide minimum redundant-sign-bit count for real and imag parts. Optional macro: CBFP_BYPASS_EN.
module cbfp_exp_detect #(
  parameter int IN_WIDTH    = 23,
  parameter int SHIFT_WIDTH = 5,
  parameter int DATA_NUM    = 16,
  parameter int LANES       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH*LANES-1:0]    in_real,
  input  logic [IN_WIDTH*LANES-1:0]    in_imag,
`ifdef CBFP_BYPASS_EN
  input  logic                         bypass,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_WIDTH*DATA_NUM-1:0] out_real,
  output logic [IN_WIDTH*DATA_NUM-1:0] out_imag,
  output logic [SHIFT_WIDTH-1:0]       shift_amt_re,
  output logic [SHIFT_WIDTH-1:0]       shift_amt_im
);

  // Handshake: a beat moves on in_valid && in_ready, a block moves on out_valid && out_ready;
  // valid never waits on ready and, once raised, out_valid holds with stable data until taken.

  localparam int BEATS = DATA_NUM / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILL, BANK_FULL} bank_state_e;

  bank_state_e          bank_state [2];
  logic                 wr_sel;
  logic                 rd_sel;
  logic                 ready_en;
  logic [CW-1:0]        beat_cnt;
  logic [IN_WIDTH-1:0]  re_mem [2][DATA_NUM];
  logic [IN_WIDTH-1:0]  im_mem [2][DATA_NUM];
  logic [SHIFT_WIDTH-1:0] min_re [2];
  logic [SHIFT_WIDTH-1:0] min_im [2];
  logic [SHIFT_WIDTH-1:0] lane_min_re;
  logic [SHIFT_WIDTH-1:0] lane_min_im;
  logic                 accept;
  logic                 handoff;
  logic                 last_beat;
`ifdef CBFP_BYPASS_EN
  localparam logic [SHIFT_WIDTH-1:0] UNITY = SHIFT_WIDTH'(12);
  logic                 byp_q [2];
`endif

  // Number of leading bits below the MSB that repeat the sign.
  function automatic logic [SHIFT_WIDTH-1:0] rsb(input logic [IN_WIDTH-1:0] x);
    logic [SHIFT_WIDTH-1:0] cnt;
    logic                   run;
    cnt = '0;
    run = 1'b1;
    for (int i = IN_WIDTH - 2; i >= 0; i--) begin
      run = run && (x[i] == x[IN_WIDTH-1]);
      if (run) cnt = cnt + SHIFT_WIDTH'(1);
    end
    return cnt;
  endfunction

  always_comb begin
    lane_min_re = rsb(in_real[IN_WIDTH-1:0]);
    lane_min_im = rsb(in_imag[IN_WIDTH-1:0]);
    for (int k = 1; k < LANES; k++) begin
      if (rsb(in_real[k*IN_WIDTH +: IN_WIDTH]) < lane_min_re)
        lane_min_re = rsb(in_real[k*IN_WIDTH +: IN_WIDTH]);
      if (rsb(in_imag[k*IN_WIDTH +: IN_WIDTH]) < lane_min_im)
        lane_min_im = rsb(in_imag[k*IN_WIDTH +: IN_WIDTH]);
    end
  end

  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));
  assign in_ready  = ready_en && (bank_state[wr_sel] != BANK_FULL);
  assign out_valid = (bank_state[rd_sel] == BANK_FULL);

  // Accept and hand-off can never target the same bank: one needs it FULL, the other not FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= BANK_EMPTY;
        min_re[b]     <= '0;
        min_im[b]     <= '0;
`ifdef CBFP_BYPASS_EN
        byp_q[b]      <= 1'b0;
`endif
        for (int i = 0; i < DATA_NUM; i++) begin
          re_mem[b][i] <= '0;
          im_mem[b][i] <= '0;
        end
      end
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      beat_cnt <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        for (int k = 0; k < LANES; k++) begin
          re_mem[wr_sel][IW'(int'(beat_cnt) * LANES + k)] <= in_real[k*IN_WIDTH +: IN_WIDTH];
          im_mem[wr_sel][IW'(int'(beat_cnt) * LANES + k)] <= in_imag[k*IN_WIDTH +: IN_WIDTH];
        end
        if (beat_cnt == '0) begin
          min_re[wr_sel] <= lane_min_re;
          min_im[wr_sel] <= lane_min_im;
`ifdef CBFP_BYPASS_EN
          byp_q[wr_sel]  <= bypass;
`endif
        end else begin
          min_re[wr_sel] <= (lane_min_re < min_re[wr_sel]) ? lane_min_re : min_re[wr_sel];
          min_im[wr_sel] <= (lane_min_im < min_im[wr_sel]) ? lane_min_im : min_im[wr_sel];
        end
        if (last_beat) begin
          bank_state[wr_sel] <= BANK_FULL;
          wr_sel             <= ~wr_sel;
          beat_cnt           <= '0;
        end else begin
          bank_state[wr_sel] <= BANK_FILL;
          beat_cnt           <= beat_cnt + CW'(1);
        end
      end
      if (handoff) begin
        bank_state[rd_sel] <= BANK_EMPTY;
        rd_sel             <= ~rd_sel;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DATA_NUM; i++) begin
      out_real[i*IN_WIDTH +: IN_WIDTH] = re_mem[rd_sel][i];
      out_imag[i*IN_WIDTH +: IN_WIDTH] = im_mem[rd_sel][i];
    end
  end

`ifdef CBFP_BYPASS_EN
  assign shift_amt_re = byp_q[rd_sel] ? UNITY : min_re[rd_sel];
  assign shift_amt_im = byp_q[rd_sel] ? UNITY : min_im[rd_sel];
`else
  assign shift_amt_re = min_re[rd_sel];
  assign shift_amt_im = min_im[rd_sel];
`endif

endmodule
